// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared types for the MEM/WB skid register:
// FSM state encoding and the default-width payload record.
package mem_wb_skid_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] mem_data;
  } payload_t;

endpackage

// File: rtl/mem_wb_skid_reg_payload.sv
// Enable-loaded payload register, cleared
// asynchronously by rst.
module stage_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register as a 2-entry skid
// buffer with writeback forwarding from the head.
module mem_wb_skid_reg
  import mem_wb_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              fwd_en,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value,
  output logic [1:0]        occupancy
);

  localparam int PW = 2 + DEST_W + 2 * DATA_W;

  state_t state_q, state_d;

  logic          in_fire, out_fire;
  logic          main_en, skid_en, main_from_skid;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic          main_wb, main_mr;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign in_pl = {in_wb_en, in_mem_r_en, in_dest,
                  in_alu_res, in_mem_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire) state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL: if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush suppresses every load; payload simply holds.
  always_comb begin
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: main_en = in_fire;
        ONE: begin
          main_en = in_fire & out_fire;
          skid_en = in_fire & ~out_fire;
        end
        FULL: begin
          main_en        = out_fire;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  stage_payload_reg #(.W(PW)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  stage_payload_reg #(.W(PW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_pl),
    .q   (skid_q)
  );

  assign {main_wb, main_mr, out_dest,
          out_alu_res, out_mem_data} = main_q;

  assign out_wb_en    = main_wb & out_valid;
  assign out_mem_r_en = main_mr & out_valid;

  assign fwd_en    = out_valid & out_wb_en;
  assign fwd_dest  = out_dest;
  assign fwd_value = out_mem_r_en ? out_mem_data
                                  : out_alu_res;
  assign occupancy = state_q;

endmodule
